// File: rtl/bp_table_ctrl_pkg.sv
// rtl/bp_table_ctrl_pkg.sv - shared defines, FSM states and counter constants for bp_table_ctrl
//
// Purpose: common definitions for the branch prediction table controller.
//   `WORD_WIDTH : default address/data width
//   `TRUE/`FALSE: single-bit boolean literals
//   bp_state_e  : drain/init FSM states
//   CTR_MAX     : saturation ceiling of the 2-bit direction counter
//   CTR_ALLOC   : counter value given to a freshly allocated entry
//   sat_step()  : saturating +/-1 on a 2-bit counter

`ifndef BP_TABLE_CTRL_DEFINES
`define BP_TABLE_CTRL_DEFINES
`define WORD_WIDTH 32
`define TRUE  1'b1
`define FALSE 1'b0
`endif

package bp_table_ctrl_pkg;

  typedef enum logic [2:0] {
    BPS_INIT = 3'd0,
    BPS_IDLE = 3'd1,
    BPS_RD   = 3'd2,
    BPS_MOD  = 3'd3,
    BPS_WR   = 3'd4
  } bp_state_e;

  localparam logic [1:0] CTR_MAX   = 2'd3;
  localparam logic [1:0] CTR_ALLOC = 2'd2;
  localparam logic [1:0] CTR_INIT  = 2'd1;

  function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic inc);
    logic [1:0] r;
    r = ctr;
    if (inc) begin
      if (ctr != CTR_MAX) r = ctr + 2'd1;
    end else begin
      if (ctr != 2'd0) r = ctr - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bp_table_ctrl_upd_fifo.sv
// rtl/bp_table_ctrl_upd_fifo.sv - synchronous FIFO buffering branch outcome updates
//
// Purpose: power-of-two deep FIFO; head is always visible on pop_data.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   push, push_data : enqueue strobe and payload (dropped when full unless popping)
//   pop             : dequeue strobe (ignored when empty)
//   pop_data        : current head entry
//   full, empty     : occupancy flags
//   count           : number of stored entries, 0..DEPTH

module bp_upd_fifo #(
  parameter int DW    = 63,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push while full still lands if the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/bp_table_ctrl.sv
// rtl/bp_table_ctrl.sv - branch target/direction table with lookup port and update drain
//
// Purpose: single-port prediction table. One fetch lookup per cycle; resolved
// outcomes are queued and merged into the table by read-modify-write. After
// reset the table is swept clean before lookups are served.
// Optional: define BP_STATS_EN to add lookup_cnt / hit_cnt / drop_cnt.
// Ports:
//   clk, rst                          : clock, asynchronous active-high reset
//   lookup_en, lookup_pc              : fetch prediction request
//   predict_valid/_j_taken/_addr      : result, one cycle after the request
//   upd, add_else_minus, upd_src_pc,
//   upd_targ                          : resolved branch outcome
//   upd_full                          : update FIFO full
//   init_busy                         : clear sweep running
//   lookup_cnt, hit_cnt, drop_cnt     : statistics (BP_STATS_EN only)

module bp_table_ctrl
  import bp_table_ctrl_pkg::*;
#(
  parameter int W       = `WORD_WIDTH,
  parameter int IDX_W   = 4,
  parameter int Q_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         lookup_en,
  input  logic [W-1:0] lookup_pc,
  output logic         predict_valid,
  output logic         predict_j_taken,
  output logic [W-1:0] predict_addr,
  input  logic         upd,
  input  logic         add_else_minus,
  input  logic [W-1:0] upd_src_pc,
  input  logic [W-1:0] upd_targ,
  output logic         upd_full,
  output logic         init_busy
`ifdef BP_STATS_EN
  ,
  output logic [31:0]  lookup_cnt,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  drop_cnt
`endif
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = W - IDX_W - 2;
  localparam int PC_W  = W - 2;
  localparam int QD_W  = 1 + PC_W + W;
  localparam int QCW   = $clog2(Q_DEPTH) + 1;

  // Table storage, one array per field.
  logic             tv_mem   [DEPTH];
  logic [TAG_W-1:0] tag_mem  [DEPTH];
  logic [W-1:0]     targ_mem [DEPTH];
  logic [1:0]       ctr_mem  [DEPTH];

  logic             tbl_we;
  logic             tbl_re;
  logic [IDX_W-1:0] tbl_idx;
  logic             wd_v;
  logic [TAG_W-1:0] wd_tag;
  logic [W-1:0]     wd_targ;
  logic [1:0]       wd_ctr;

  logic             rd_v;
  logic [TAG_W-1:0] rd_tag;
  logic [W-1:0]     rd_targ;
  logic [1:0]       rd_ctr;

  // Update FIFO.
  logic             q_pop;
  logic [QD_W-1:0]  q_head;
  logic             q_full;
  logic             q_empty;
  logic [QCW-1:0]   q_count;

  bp_upd_fifo #(
    .DW    (QD_W),
    .DEPTH (Q_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (upd),
    .push_data ({add_else_minus, upd_src_pc[W-1:2], upd_targ}),
    .pop       (q_pop),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{lookup_pc[1:0], upd_src_pc[1:0]};

  // FSM, sweep and lookup pipeline state.
  bp_state_e        state_q, state_d;
  logic [IDX_W-1:0] sweep_q;
  logic             lk_v_q;
  logic             lk_g_q;
  logic [TAG_W-1:0] lk_tag_q;

  // Update being merged, and the entry computed for it.
  logic             hold_load;
  logic             hold_taken;
  logic [PC_W-1:0]  hold_pc;
  logic [W-1:0]     hold_targ;
  logic             ent_load;
  logic [1:0]       ent_ctr;
  logic [W-1:0]     ent_targ;

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] hold_idx;
  logic [TAG_W-1:0] hold_tag;
  logic             lk_accept;
  logic             lk_grant;
  logic             lk_hit;
  logic             mod_hit;
  logic [1:0]       mod_ctr;
  logic [W-1:0]     mod_targ;

  assign lk_idx   = lookup_pc[IDX_W+1:2];
  assign head_idx = q_head[W +: IDX_W];
  assign hold_idx = hold_pc[IDX_W-1:0];
  assign hold_tag = hold_pc[PC_W-1:IDX_W];

  // A lookup gets the port unless a full FIFO needs draining; a lookup
  // that loses still answers, as "not taken".
  assign lk_accept = lookup_en && (state_q != BPS_INIT);
  assign lk_grant  = lk_accept && !q_full;

  assign mod_hit  = rd_v && (rd_tag == hold_tag);
  assign mod_ctr  = mod_hit ? sat_step(rd_ctr, hold_taken) : CTR_ALLOC;
  assign mod_targ = (mod_hit && !hold_taken) ? rd_targ : hold_targ;

  always_comb begin
    state_d   = state_q;
    tbl_we    = 1'b0;
    tbl_re    = lk_grant;
    tbl_idx   = lk_idx;
    wd_v      = 1'b1;
    wd_tag    = hold_tag;
    wd_targ   = ent_targ;
    wd_ctr    = ent_ctr;
    q_pop     = 1'b0;
    hold_load = 1'b0;
    ent_load  = 1'b0;
    case (state_q)
      BPS_INIT: begin
        tbl_we  = 1'b1;
        tbl_idx = sweep_q;
        wd_v    = 1'b0;
        wd_tag  = '0;
        wd_targ = '0;
        wd_ctr  = CTR_INIT;
        if (sweep_q == IDX_W'(DEPTH - 1)) state_d = BPS_IDLE;
      end
      BPS_IDLE: begin
        if (!q_empty) state_d = BPS_RD;
      end
      BPS_RD: begin
        if (!lk_grant && !q_empty) begin
          tbl_re    = 1'b1;
          tbl_idx   = head_idx;
          q_pop     = 1'b1;
          hold_load = 1'b1;
          state_d   = BPS_MOD;
        end
      end
      BPS_MOD: begin
        // A not-taken outcome for an unknown branch leaves the table alone.
        if (mod_hit || hold_taken) begin
          ent_load = 1'b1;
          state_d  = BPS_WR;
        end else begin
          state_d  = BPS_IDLE;
        end
      end
      BPS_WR: begin
        if (!lk_grant) begin
          tbl_we  = 1'b1;
          tbl_idx = hold_idx;
          // Chain straight into the next read to sustain one update per 3 cycles.
          state_d = q_empty ? BPS_IDLE : BPS_RD;
        end
      end
      default: state_d = BPS_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= BPS_INIT;
      sweep_q  <= '0;
      lk_v_q   <= 1'b0;
      lk_g_q   <= 1'b0;
      lk_tag_q <= '0;
    end else begin
      state_q  <= state_d;
      if (state_q == BPS_INIT) sweep_q <= sweep_q + IDX_W'(1);
      lk_v_q   <= lk_accept;
      lk_g_q   <= lk_grant;
      lk_tag_q <= lookup_pc[W-1:IDX_W+2];
    end
  end

  always_ff @(posedge clk) begin
    if (hold_load) {hold_taken, hold_pc, hold_targ} <= q_head;
    if (ent_load) begin
      ent_ctr  <= mod_ctr;
      ent_targ <= mod_targ;
    end
  end

  // Single-port table with registered read data.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tv_mem[tbl_idx]   <= wd_v;
      tag_mem[tbl_idx]  <= wd_tag;
      targ_mem[tbl_idx] <= wd_targ;
      ctr_mem[tbl_idx]  <= wd_ctr;
    end else if (tbl_re) begin
      rd_v    <= tv_mem[tbl_idx];
      rd_tag  <= tag_mem[tbl_idx];
      rd_targ <= targ_mem[tbl_idx];
      rd_ctr  <= ctr_mem[tbl_idx];
    end
  end

  // Read data only belongs to the lookup when it actually won the port.
  assign lk_hit          = lk_g_q && rd_v && (rd_tag == lk_tag_q);
  assign predict_valid   = lk_v_q;
  assign predict_j_taken = lk_v_q && lk_hit && rd_ctr[1];
  assign predict_addr    = (lk_v_q && lk_hit) ? rd_targ : '0;
  assign upd_full        = (q_count == QCW'(Q_DEPTH));
  assign init_busy       = (state_q == BPS_INIT);

`ifdef BP_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lookup_cnt <= '0;
      hit_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      if (lk_accept)                 lookup_cnt <= lookup_cnt + 32'd1;
      if (lk_v_q && lk_hit)          hit_cnt    <= hit_cnt + 32'd1;
      if (upd && q_full && !q_pop)   drop_cnt   <= drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_table_ctrl.sv
// tb/tb_bp_table_ctrl.sv - scoreboard testbench for bp_table_ctrl

module tb_bp_table_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_en;
  logic [31:0] lookup_pc;
  logic        predict_valid;
  logic        predict_j_taken;
  logic [31:0] predict_addr;
  logic        upd;
  logic        add_else_minus;
  logic [31:0] upd_src_pc;
  logic [31:0] upd_targ;
  logic        upd_full;
  logic        init_busy;
`ifdef BP_STATS_EN
  logic [31:0] lookup_cnt;
  logic [31:0] hit_cnt;
  logic [31:0] drop_cnt;
`endif

  bp_table_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .lookup_en       (lookup_en),
    .lookup_pc       (lookup_pc),
    .predict_valid   (predict_valid),
    .predict_j_taken (predict_j_taken),
    .predict_addr    (predict_addr),
    .upd             (upd),
    .add_else_minus  (add_else_minus),
    .upd_src_pc      (upd_src_pc),
    .upd_targ        (upd_targ),
    .upd_full        (upd_full),
    .init_busy       (init_busy)
`ifdef BP_STATS_EN
    ,
    .lookup_cnt      (lookup_cnt),
    .hit_cnt         (hit_cnt),
    .drop_cnt        (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        taken;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];

  // Reference table: 16 entries indexed by pc[5:2], tag pc[31:6].
  logic        m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_targ  [16];
  int          m_ctr   [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_targ[i]  = '0;
      m_ctr[i]   = 1;
    end
  endfunction

  function automatic void model_update(input logic [31:0] pc, input logic taken, input logic [31:0] targ);
    int i;
    i = int'(pc[5:2]);
    if (m_valid[i] && m_tag[i] == pc[31:6]) begin
      if (taken) begin
        m_ctr[i]  = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_targ[i] = targ;
      end else begin
        m_ctr[i]  = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (taken) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = pc[31:6];
      m_targ[i]  = targ;
      m_ctr[i]   = 2;
    end
  endfunction

  function automatic exp_t model_predict(input logic [31:0] pc);
    exp_t e;
    int   i;
    i = int'(pc[5:2]);
    e.taken = 1'b0;
    e.addr  = '0;
    if (m_valid[i] && m_tag[i] == pc[31:6]) begin
      e.taken = (m_ctr[i] >= 2);
      e.addr  = m_targ[i];
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] t;
    logic [31:0] ix;
    t  = $urandom_range(0, 2);
    ix = $urandom_range(0, 15);
    return (t << 6) | (ix << 2);
  endfunction

  task automatic do_lookup(input logic [31:0] pc);
    lookup_en = 1'b1;
    lookup_pc = pc;
    exp_q.push_back(model_predict(pc));
    @(negedge clk);
    lookup_en = 1'b0;
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic taken, input logic [31:0] targ, input bit to_model);
    upd            = 1'b1;
    upd_src_pc     = pc;
    add_else_minus = taken;
    upd_targ       = targ;
    if (to_model) model_update(pc, taken, targ);
    @(negedge clk);
    upd = 1'b0;
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    for (int c = 0; c < 64 && init_busy; c++) begin
      n++;
      @(negedge clk);
    end
    check(name, n, 16);
  endtask

  // Monitor: every presented prediction is matched against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (predict_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_predict", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("predict_taken", {31'd0, predict_j_taken}, {31'd0, e.taken});
          check("predict_addr", predict_addr, e.addr);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] T_PC = 32'h0000_00C4;

  initial begin
    rst            = 1'b1;
    lookup_en      = 1'b0;
    lookup_pc      = '0;
    upd            = 1'b0;
    add_else_minus = 1'b0;
    upd_src_pc     = '0;
    upd_targ       = '0;
    model_clear();

    repeat (2) @(negedge clk);
    check("rst_predict_valid", {31'd0, predict_valid}, 32'd0);
    check("rst_predict_taken", {31'd0, predict_j_taken}, 32'd0);
    check("rst_predict_addr", predict_addr, 32'd0);
    check("rst_upd_full", {31'd0, upd_full}, 32'd0);
    check("rst_init_busy", {31'd0, init_busy}, 32'd1);

    // Release reset with a lookup pending: it must not be answered.
    rst       = 1'b0;
    lookup_en = 1'b1;
    lookup_pc = 32'h100;
    begin
      int n;
      n = 0;
      for (int c = 0; c < 64 && init_busy; c++) begin
        n++;
        @(negedge clk);
        if (c == 0) begin
          lookup_en = 1'b0;
          check("init_lookup_valid", {31'd0, predict_valid}, 32'd0);
        end
      end
      check("init_busy_cycles", n, 16);
    end

    // Directed sequence on pc 0x100.
    do_lookup(32'h100);
    repeat (2) @(negedge clk);
    do_upd(32'h100, 1'b1, 32'h200, 1'b1);
    repeat (8) @(negedge clk);
    do_lookup(32'h100);
    do_lookup(32'h140);
    for (int k = 0; k < 3; k++) begin
      do_upd(32'h100, 1'b0, 32'h0, 1'b1);
      repeat (8) @(negedge clk);
      do_lookup(32'h100);
    end
    do_upd(32'h100, 1'b1, 32'h204, 1'b1);
    repeat (8) @(negedge clk);
    do_lookup(32'h100);

    // Full-FIFO priority: lookups hold the port, five updates arrive back-to-back.
    do_upd(T_PC, 1'b1, 32'hABC0, 1'b1);
    repeat (10) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (k == 3) check("full_before_4th", {31'd0, upd_full}, 32'd0);
      if (k == 4) check("full_after_4", {31'd0, upd_full}, 32'd1);
      lookup_en = 1'b1;
      lookup_pc = T_PC;
      if (k < 4) exp_q.push_back(model_predict(T_PC));
      else       exp_q.push_back('0);
      // Not-taken outcomes for unknown branches never change the table.
      upd            = 1'b1;
      upd_src_pc     = 32'h4000_0000 | (k << 2);
      add_else_minus = 1'b0;
      upd_targ       = 32'h0;
      @(negedge clk);
    end
    lookup_en = 1'b0;
    upd       = 1'b0;
    repeat (40) @(negedge clk);
    check("full_cleared", {31'd0, upd_full}, 32'd0);
    do_lookup(T_PC);

    // Randomized update bursts followed by lookup bursts.
    for (int r = 0; r < 30; r++) begin
      int nu;
      int nl;
      nu = $urandom_range(1, 4);
      for (int u = 0; u < nu; u++)
        do_upd(rand_pc(), 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 1'b1);
      repeat (24) @(negedge clk);
      nl = $urandom_range(2, 8);
      for (int l = 0; l < nl; l++) begin
        do_lookup(rand_pc());
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      repeat (3) @(negedge clk);
    end

    // Reset while an allocation is about to be written.
    do_upd(32'h0000_1238, 1'b1, 32'h5550, 1'b0);
    do_upd(32'h0000_0A14, 1'b1, 32'h6660, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_init_busy", {31'd0, init_busy}, 32'd1);
    check("midrst_upd_full", {31'd0, upd_full}, 32'd0);
    rst = 1'b0;
    model_clear();
    wait_init("reinit_busy_cycles");
    repeat (20) @(negedge clk);
    do_lookup(32'h0000_1238);
    do_lookup(32'h0000_0A14);
    do_lookup(32'h100);

    repeat (4) @(negedge clk);
    check("pending_predicts", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
